bitonic_search64: RTL
=====================

// Module: bitonic_search64
// PURPOSE
//  Sequential search engine downstream of the 64-element bitonic merge stage.
//  - Snapshots the sorted 64-word bus (merge out_bus) and a search key on start.
//  - Runs a fixed-length 6-step binary rank search, then one check cycle.
//  - Reports the lowest index whose element equals the key, and the key's rank.
//  Forms the "searching" half of the sort/search accelerator.
// PARAMETERS
//  WIDTH  32  element and key width in bits; unsigned compare
//  N      64  element count; fixed to 64, index widths derived as 6/7 bits
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous active-low reset
//  start       in   1         request a search; honoured only while busy==0
//  direction   in   1         order of sorted_bus: 0 = ascending, 1 = descending
//  key         in   WIDTH     value to search for
//  sorted_bus  in   64*WIDTH  element i at [i*WIDTH +: WIDTH], sorted per direction
//  busy        out  1         search in progress; start is ignored while high
//  done        out  1         one-cycle pulse: results valid, held until next start
//  found       out  1         1 = at least one element equals key
//  index       out  7         rank: # elements strictly preceding key (0..64);
//                             when found, this is the lowest matching index
// BEHAVIOUR
//  - Reset (async, rst_n low):
//    - state=IDLE; busy=0, done=0, found=0, index=0.
//    - Internal snapshot and position counter are cleared.
//    - A reset mid-search aborts it with no done pulse.
//  - "precedes(a,key)" means a<key when dir=0 and a>key when dir=1 (unsigned).
//  - FSM state IDLE:
//    - At an edge with start=1, latch sorted_bus, key and direction.
//    - Set pos=0 and step=32, go to SEARCH, set busy=1.
//    - done is cleared at every edge, so it is high for exactly one cycle.
//  - FSM state SEARCH (6 edges, step=32,16,8,4,2,1):
//    - If precedes(snap[pos+step-1], key), then pos += step.
//    - step >>= 1; after the step==1 edge, go to CHECK.
//  - FSM state CHECK (1 edge):
//    - index <= pos.
//    - found <= (pos<64) && snap[pos]==key. pos==64 must not read out of range.
//    - done <= 1, busy <= 0, go to IDLE.
//  - Latency: start sampled at edge E0; done, found and index update at E7.
//    - done is high between E7 and E8.
//    - Throughput is one search per 8 cycles.
//  - start while busy=1 is ignored, and the snapshot is not disturbed.
//  - start=1 in the cycle done is high is accepted; back-to-back searches allowed.
//  - found/index hold their last values until the next CHECK. They are not cleared on start.
//  - sorted_bus may change freely after the start edge, because the snapshot is used.
//  - Duplicates: the rank search returns the first occurrence.
//  - Unsorted input: results are undefined but the FSM must still complete in 7 edges.
// TESTING
//  - asc data[i]=2i, key=40 -> done at E7, found=1, index=20.
//  - asc data[i]=2i, key=41 -> found=0, index=21. key=200 -> found=0, index=64.
//    key=0 -> found=1, index=0.
//  - desc data[i]=126-2i, direction=1, key=40 -> found=1, index=43.
//    key=127 -> found=0, index=0.
//  - all elements=5, key=5 -> found=1, index=0. key=6 -> found=0, index=64.
//  - start pulsed at E2 and E4 of a running search -> ignored, single done at E7.
//    start held high through done -> next done at E15.
//  - rst_n low at E3 of a search -> busy/done/found/index=0 immediately, no done pulse.
//    After release, a new search completes normally.

Source files
------------

// File: rtl/bitonic_search64.sv
// Sequential rank search over a snapshot of a sorted 64-word bus.
// The snapshot is taken on start. After six binary steps and one check cycle, the block reports the lowest matching index and the key's rank.
module bitonic_search64 #(
  parameter int WIDTH = 32,
  parameter int N     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               direction,
  input  logic [WIDTH-1:0]   key,
  input  logic [N*WIDTH-1:0] sorted_bus,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [6:0]         index
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] snap_q [N];
  logic [WIDTH-1:0] key_q, key_d;
  logic             dir_q, dir_d;
  logic [6:0]       pos_q, pos_d;
  logic [6:0]       step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [6:0]       index_q, index_d;
  logic             load;

  logic [6:0]       probe;
  logic [WIDTH-1:0] probe_val;
  logic [WIDTH-1:0] pos_val;
  logic             probe_precedes;
  logic             pos_precedes;

  function automatic logic precedes(input logic dir, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] k);
    return dir ? (a > k) : (a < k);
  endfunction

  // The step sum is 63, so pos stays within 0..63 and every read is in range.
  assign probe          = pos_q + step_q - 7'd1;
  assign probe_val      = snap_q[probe[5:0]];
  assign pos_val        = snap_q[pos_q[5:0]];
  assign probe_precedes = precedes(dir_q, probe_val, key_q);
  assign pos_precedes   = precedes(dir_q, pos_val, key_q);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    found_d = found_q;
    index_d = index_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          key_d   = key;
          dir_d   = direction;
          pos_d   = 7'd0;
          step_d  = 7'd32;
          busy_d  = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (probe_precedes) pos_d = pos_q + step_q;
        step_d = step_q >> 1;
        if (step_q == 7'd1) state_d = CHECK;
      end
      CHECK: begin
        // If the last element also precedes the key, every element does, so the rank is 64.
        index_d = pos_q + {6'd0, pos_precedes};
        found_d = (pos_val == key_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      index_q <= index_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) snap_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) snap_q[i] <= sorted_bus[i*WIDTH +: WIDTH];
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign index = index_q;

endmodule
